vend_fsm_param: RTL and testbench

//  Parametrised coin-operated vending controller. Price is set at elaboration.

---
 rtl/vend_pkg.sv | 14 +
 rtl/vend_fsm_param_if.sv | 28 ++
 rtl/vend_change_sel.sv | 38 +++
 rtl/vend_fsm_param.sv | 104 ++++++++++
 tb/tb_vend_fsm_param.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared constants and state encoding for the vending controller.
package vend_pkg;

   localparam int VAL_N = 5;
   localparam int VAL_D = 10;
   localparam int VAL_Q = 25;

   typedef enum logic [1:0] {
      ACCEPT = 2'd0,
      VEND   = 2'd1,
      CHANGE = 2'd2
   } state_e;

endpackage

// File: rtl/vend_fsm_param_if.sv
// Coin-sense inputs and dispenser/change outputs of the vending controller.
interface vend_fsm_param_if #(
   parameter int CREDIT_W = 8
);

   logic                N;
   logic                D;
   logic                Q;
   logic                cancel;
   logic                Y;
   logic                chg_n;
   logic                chg_d;
   logic                chg_q;
   logic                coin_rej;
   logic                busy;
   logic [CREDIT_W-1:0] credit;

   modport master (
      output N, D, Q, cancel,
      input  Y, chg_n, chg_d, chg_q, coin_rej, busy, credit
   );

   modport slave (
      input  N, D, Q, cancel,
      output Y, chg_n, chg_d, chg_q, coin_rej, busy, credit
   );

endinterface

// File: rtl/vend_change_sel.sv
// Greedy change-coin picker: largest coin not exceeding the credit.
module vend_change_sel
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 8
) (
   input  logic [CREDIT_W-1:0] credit,
   output logic                q,
   output logic                d,
   output logic                n,
   output logic [CREDIT_W-1:0] sub
);

   logic ge_q;
   logic ge_d;

   assign ge_q = credit >= CREDIT_W'(VAL_Q);
   assign ge_d = !ge_q && (credit >= CREDIT_W'(VAL_D));

   always_comb begin
      q   = 1'b0;
      d   = 1'b0;
      n   = 1'b0;
      sub = CREDIT_W'(VAL_N);
      unique case (1'b1)
         ge_q: begin
            q   = 1'b1;
            sub = CREDIT_W'(VAL_Q);
         end
         ge_d: begin
            d   = 1'b1;
            sub = CREDIT_W'(VAL_D);
         end
         default: n = 1'b1;
      endcase
   end

endmodule

// File: rtl/vend_fsm_param.sv
// Coin-operated vending controller: credit accumulate, vend, greedy change.
module vend_fsm_param
   import vend_pkg::*;
#(
   parameter int PRICE    = 35,
   parameter int CREDIT_W = 8
) (
   input logic             clk,
   input logic             reset,
   vend_fsm_param_if.slave bus
);

   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                coin_rej_q, coin_rej_d;

   logic [1:0]          coin_cnt;
   logic                one_coin;
   logic                multi_coin;
   logic                any_coin;
   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W-1:0] sum;
   logic [CREDIT_W-1:0] rem;
   logic [CREDIT_W-1:0] left;
   logic [CREDIT_W-1:0] sub;
   logic                sel_q, sel_d, sel_n;

   vend_change_sel #(.CREDIT_W(CREDIT_W)) u_sel (
      .credit (credit_q),
      .q      (sel_q),
      .d      (sel_d),
      .n      (sel_n),
      .sub    (sub)
   );

   assign coin_cnt   = {1'b0, bus.N} + {1'b0, bus.D} + {1'b0, bus.Q};
   assign one_coin   = coin_cnt == 2'd1;
   assign multi_coin = coin_cnt > 2'd1;
   assign any_coin   = coin_cnt != 2'd0;

   // Only meaningful when exactly one coin line is high.
   assign coin_val = bus.Q ? CREDIT_W'(VAL_Q) :
                     bus.D ? CREDIT_W'(VAL_D) :
                             CREDIT_W'(VAL_N);

   assign sum  = credit_q + coin_val;
   assign rem  = credit_q - PRICE_C;
   assign left = credit_q - sub;

   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      coin_rej_d = 1'b0;
      case (state_q)
         ACCEPT: begin
            if (one_coin) begin
               credit_d = sum;
               if (sum >= PRICE_C) state_d = VEND;
            end else if (multi_coin) begin
               coin_rej_d = 1'b1;
            end else if (bus.cancel && credit_q != '0) begin
               state_d = CHANGE;
            end
         end
         VEND: begin
            coin_rej_d = any_coin;
            credit_d   = rem;
            state_d    = (rem == '0) ? ACCEPT : CHANGE;
         end
         CHANGE: begin
            coin_rej_d = any_coin;
            credit_d   = left;
            if (left == '0) state_d = ACCEPT;
         end
         default: begin
            state_d  = ACCEPT;
            credit_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ACCEPT;
         credit_q   <= '0;
         coin_rej_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         coin_rej_q <= coin_rej_d;
      end
   end

   assign bus.Y        = state_q == VEND;
   assign bus.busy     = (state_q == VEND) || (state_q == CHANGE);
   assign bus.chg_q    = (state_q == CHANGE) && sel_q;
   assign bus.chg_d    = (state_q == CHANGE) && sel_d;
   assign bus.chg_n    = (state_q == CHANGE) && sel_n;
   assign bus.coin_rej = coin_rej_q;
   assign bus.credit   = credit_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Scoreboard bench for vend_fsm_param at PRICE=35 and PRICE=5.
module tb_vend_fsm_param;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   vend_fsm_param_if #(.CREDIT_W(8)) b35 ();
   vend_fsm_param_if #(.CREDIT_W(8)) b5 ();

   vend_fsm_param #(.PRICE(35), .CREDIT_W(8)) dut35 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (b35)
   );

   vend_fsm_param #(.PRICE(5), .CREDIT_W(8)) dut5 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (b5)
   );

   typedef struct {
      string       tag;
      logic        r, n, d, q, c, sel;
      logic [13:0] exp;
   } vec_t;

   typedef struct {
      string       tag;
      logic        sel;
      logic [13:0] exp;
   } exp_t;

   vec_t vq[$];
   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;

   exp_t        me;
   logic [13:0] act;

   // Expected output word: {Y, chg_n, chg_d, chg_q, coin_rej, busy, credit}
   function automatic logic [13:0] pk(logic y, logic cn, logic cd, logic cq,
                                      logic rj, logic bz, int cr);
      return {y, cn, cd, cq, rj, bz, 8'(cr)};
   endfunction

   task automatic add(string tag, logic r, logic n, logic d, logic q,
                      logic c, logic sel, logic [13:0] e);
      vec_t v;
      v.tag = tag; v.r = r; v.n = n; v.d = d; v.q = q; v.c = c;
      v.sel = sel; v.exp = e;
      vq.push_back(v);
   endtask

   task automatic drive(logic r, logic n, logic d, logic q, logic c);
      rst_n     = r;
      b35.N     = n; b35.D = d; b35.Q = q; b35.cancel = c;
      b5.N      = n; b5.D  = d; b5.Q  = q; b5.cancel  = c;
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         me  = sb.pop_front();
         act = me.sel ?
               {b5.Y, b5.chg_n, b5.chg_d, b5.chg_q, b5.coin_rej, b5.busy, b5.credit} :
               {b35.Y, b35.chg_n, b35.chg_d, b35.chg_q, b35.coin_rej, b35.busy, b35.credit};
         total++;
         if (act === me.exp) passed++;
         else $display("FAIL %s: got %b expected %b", me.tag, act, me.exp);
      end
   end

   initial begin
      exp_t e;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      //   tag          r n d q c s  Y n d q rj bz cr
      add("reset",      0,0,0,0,0,0, pk(0,0,0,0,0,0, 0));
      add("dq_d",       1,0,1,0,0,0, pk(0,0,0,0,0,0,10));
      add("dq_q",       1,0,0,1,0,0, pk(1,0,0,0,0,1,35));
      add("dq_done",    1,0,0,0,0,0, pk(0,0,0,0,0,0, 0));
      add("dq_idle",    1,0,0,0,0,0, pk(0,0,0,0,0,0, 0));
      add("qq_q1",      1,0,0,1,0,0, pk(0,0,0,0,0,0,25));
      add("qq_vend",    1,0,0,1,0,0, pk(1,0,0,0,0,1,50));
      add("qq_chg_d",   1,0,0,0,0,0, pk(0,0,1,0,0,1,15));
      add("qq_chg_n",   1,0,0,0,0,0, pk(0,1,0,0,0,1, 5));
      add("qq_done",    1,0,0,0,0,0, pk(0,0,0,0,0,0, 0));
      add("cx_n",       1,1,0,0,0,0, pk(0,0,0,0,0,0, 5));
      add("cx_d",       1,0,1,0,0,0, pk(0,0,0,0,0,0,15));
      add("cx_chg_d",   1,0,0,0,1,0, pk(0,0,1,0,0,1,15));
      add("cx_chg_n",   1,0,0,0,0,0, pk(0,1,0,0,0,1, 5));
      add("cx_done",    1,0,0,0,0,0, pk(0,0,0,0,0,0, 0));
      add("rej_nd",     1,1,1,0,0,0, pk(0,0,0,0,1,0, 0));
      add("rej_clr",    1,0,0,0,0,0, pk(0,0,0,0,0,0, 0));
      add("cancel_0",   1,0,0,0,1,0, pk(0,0,0,0,0,0, 0));
      add("pri_n",      1,1,0,0,0,0, pk(0,0,0,0,0,0, 5));
      add("pri_dc",     1,0,1,0,1,0, pk(0,0,0,0,0,0,15));
      add("pri_cancel", 1,0,0,0,1,0, pk(0,0,1,0,0,1,15));
      add("pri_chg_n",  1,0,0,0,0,0, pk(0,1,0,0,0,1, 5));
      add("pri_done",   1,0,0,0,0,0, pk(0,0,0,0,0,0, 0));
      add("bz_q1",      1,0,0,1,0,0, pk(0,0,0,0,0,0,25));
      add("bz_vend",    1,0,0,1,0,0, pk(1,0,0,0,0,1,50));
      add("bz_chg_d",   1,0,0,0,0,0, pk(0,0,1,0,0,1,15));
      add("bz_n_rej",   1,1,0,0,0,0, pk(0,1,0,0,1,1, 5));
      add("bz_done",    1,0,0,0,0,0, pk(0,0,0,0,0,0, 0));
      add("mx_n",       1,1,0,0,0,0, pk(0,0,0,0,0,0, 5));
      add("mx_q",       1,0,0,1,0,0, pk(0,0,0,0,0,0,30));
      add("mx_vend",    1,0,0,1,0,0, pk(1,0,0,0,0,1,55));
      add("mx_d_rej",   1,0,1,0,0,0, pk(0,0,1,0,1,1,20));
      add("mx_cancel",  1,0,0,0,1,0, pk(0,0,1,0,0,1,10));
      add("mx_done",    1,0,0,0,0,0, pk(0,0,0,0,0,0, 0));
      add("rs_q1",      1,0,0,1,0,0, pk(0,0,0,0,0,0,25));
      add("rs_vend",    1,0,0,1,0,0, pk(1,0,0,0,0,1,50));
      add("rs_chg_d",   1,0,0,0,0,0, pk(0,0,1,0,0,1,15));
      add("rs_reset",   0,0,0,0,0,0, pk(0,0,0,0,0,0, 0));
      add("rs_after",   1,0,0,0,0,0, pk(0,0,0,0,0,0, 0));
      add("p5_reset",   0,0,0,0,0,1, pk(0,0,0,0,0,0, 0));
      add("p5_vend",    1,0,0,1,0,1, pk(1,0,0,0,0,1,25));
      add("p5_chg_d1",  1,0,0,0,0,1, pk(0,0,1,0,0,1,20));
      add("p5_chg_d2",  1,0,0,0,0,1, pk(0,0,1,0,0,1,10));
      add("p5_done",    1,0,0,0,0,1, pk(0,0,0,0,0,0, 0));

      foreach (vq[i]) begin
         @(negedge clk);
         #1;
         drive(vq[i].r, vq[i].n, vq[i].d, vq[i].q, vq[i].c);
         e.tag = vq[i].tag;
         e.sel = vq[i].sel;
         e.exp = vq[i].exp;
         sb.push_back(e);
      end

      @(negedge clk);
      #1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         total++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
